// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter that shares one I2C transaction engine between NUM_REQ pollers,
// launching each winner's transaction with a per-transaction timeout and an idle gap afterwards.
module i2c_txn_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 2700000,
    parameter int GAP_CYCLES     = 270
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [7*NUM_REQ-1:0]    req_addr,
    input  logic [NUM_REQ-1:0]      req_rw,
    input  logic [16*NUM_REQ-1:0]   req_wdata,
    input  logic [2*NUM_REQ-1:0]    req_nbytes,
    output logic [NUM_REQ-1:0]      grant,
    output logic [NUM_REQ-1:0]      done,
    output logic                    nack,
    output logic                    timeout,
    output logic [15:0]             rdata,
    output logic                    busy,
    output logic                    eng_start,
    output logic                    eng_abort,
    output logic [6:0]              eng_addr,
    output logic                    eng_rw,
    output logic [15:0]             eng_wdata,
    output logic [1:0]              eng_nbytes,
    input  logic                    eng_done,
    input  logic                    eng_nack,
    input  logic [15:0]             eng_rdata
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GW = $clog2(GAP_CYCLES + 2);
    localparam logic [IW:0]   NUM_REQ_W = (IW+1)'(NUM_REQ);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_REQ - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
    localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
    localparam logic          GAP_EN    = (GAP_CYCLES != 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_GAP   = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [IW-1:0]       ptr_q, ptr_d;
    logic [IW-1:0]       widx_q, widx_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [GW-1:0]       gap_cnt_q, gap_cnt_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic                nack_q, nack_d;
    logic                timeout_q, timeout_d;
    logic [15:0]         rdata_q, rdata_d;
    logic                busy_q, busy_d;
    logic                eng_start_q, eng_start_d;
    logic                eng_abort_q, eng_abort_d;
    logic [6:0]          eng_addr_q, eng_addr_d;
    logic                eng_rw_q, eng_rw_d;
    logic [15:0]         eng_wdata_q, eng_wdata_d;
    logic [1:0]          eng_nbytes_q, eng_nbytes_d;

    logic                pick_found_s;
    logic [IW-1:0]       pick_idx_s;
    logic [IW:0]         cand_s;
    logic [1:0]          nb_raw_s;
    logic                exit_s;

    // Round-robin scan from ptr upward with wrap; first requesting index wins.
    always_comb begin
        pick_found_s = 1'b0;
        pick_idx_s   = '0;
        cand_s       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_s = {1'b0, ptr_q} + (IW+1)'(i);
            cand_s = (cand_s >= NUM_REQ_W) ? (cand_s - NUM_REQ_W) : cand_s;
            if (!pick_found_s && req[cand_s[IW-1:0]]) begin
                pick_found_s = 1'b1;
                pick_idx_s   = cand_s[IW-1:0];
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    // Sequencer next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        widx_d       = widx_q;
        cnt_d        = cnt_q;
        gap_cnt_d    = gap_cnt_q;
        grant_d      = grant_q;
        done_d       = '0;
        nack_d       = nack_q;
        timeout_d    = timeout_q;
        rdata_d      = rdata_q;
        eng_start_d  = 1'b0;
        eng_abort_d  = 1'b0;
        eng_addr_d   = eng_addr_q;
        eng_rw_d     = eng_rw_q;
        eng_wdata_d  = eng_wdata_q;
        eng_nbytes_d = eng_nbytes_q;
        exit_s       = 1'b0;
        nb_raw_s     = req_nbytes[2*int'(pick_idx_s) +: 2];

        case (state_q)
            S_IDLE: begin
                grant_d = '0;
                if (pick_found_s) begin
                    grant_d[pick_idx_s] = 1'b1;
                    widx_d       = pick_idx_s;
                    eng_addr_d   = req_addr[7*int'(pick_idx_s) +: 7];
                    eng_rw_d     = req_rw[pick_idx_s];
                    eng_wdata_d  = req_wdata[16*int'(pick_idx_s) +: 16];
                    // Byte counts 0 and 3 are not legal lengths; run them as 2.
                    eng_nbytes_d = (nb_raw_s == 2'd1) ? 2'd1 : 2'd2;
                    state_d      = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                eng_start_d = 1'b1;
                cnt_d       = '0;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                if (eng_done) begin
                    done_d    = grant_q;
                    nack_d    = eng_nack;
                    timeout_d = 1'b0;
                    rdata_d   = eng_rw_q ? eng_rdata : rdata_q;
                    exit_s    = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    done_d      = grant_q;
                    nack_d      = 1'b1;
                    timeout_d   = 1'b1;
                    eng_abort_d = 1'b1;
                    exit_s      = 1'b1;
                end else begin
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CW'(1));
                end
                if (exit_s) begin
                    ptr_d     = (widx_q == IDX_LAST) ? '0 : (widx_q + IW'(1));
                    gap_cnt_d = '0;
                    state_d   = GAP_EN ? S_GAP : S_IDLE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_GAP: begin
                grant_d = '0;
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset clears every output without aborting the engine.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            widx_q       <= '0;
            cnt_q        <= '0;
            gap_cnt_q    <= '0;
            grant_q      <= '0;
            done_q       <= '0;
            nack_q       <= 1'b0;
            timeout_q    <= 1'b0;
            rdata_q      <= 16'h0000;
            busy_q       <= 1'b0;
            eng_start_q  <= 1'b0;
            eng_abort_q  <= 1'b0;
            eng_addr_q   <= 7'h00;
            eng_rw_q     <= 1'b0;
            eng_wdata_q  <= 16'h0000;
            eng_nbytes_q <= 2'd0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            widx_q       <= widx_d;
            cnt_q        <= cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            grant_q      <= grant_d;
            done_q       <= done_d;
            nack_q       <= nack_d;
            timeout_q    <= timeout_d;
            rdata_q      <= rdata_d;
            busy_q       <= busy_d;
            eng_start_q  <= eng_start_d;
            eng_abort_q  <= eng_abort_d;
            eng_addr_q   <= eng_addr_d;
            eng_rw_q     <= eng_rw_d;
            eng_wdata_q  <= eng_wdata_d;
            eng_nbytes_q <= eng_nbytes_d;
        end
    end

    assign grant      = grant_q;
    assign done       = done_q;
    assign nack       = nack_q;
    assign timeout    = timeout_q;
    assign rdata      = rdata_q;
    assign busy       = busy_q;
    assign eng_start  = eng_start_q;
    assign eng_abort  = eng_abort_q;
    assign eng_addr   = eng_addr_q;
    assign eng_rw     = eng_rw_q;
    assign eng_wdata  = eng_wdata_q;
    assign eng_nbytes = eng_nbytes_q;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Directed self-checking bench for i2c_txn_arbiter with 4 requesters,
// a 100-cycle timeout and a 4-cycle gap; the engine is modelled by hand-timed pulses.
module tb_i2c_txn_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [27:0] req_addr;
    logic [3:0]  req_rw;
    logic [63:0] req_wdata;
    logic [7:0]  req_nbytes;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic        nack;
    logic        timeout;
    logic [15:0] rdata;
    logic        busy;
    logic        eng_start;
    logic        eng_abort;
    logic [6:0]  eng_addr;
    logic        eng_rw;
    logic [15:0] eng_wdata;
    logic [1:0]  eng_nbytes;
    logic        eng_done;
    logic        eng_nack;
    logic [15:0] eng_rdata;

    int errors = 0;
    int checks = 0;
    int start_cnt = 0;
    logic multihot_seen = 1'b0;

    i2c_txn_arbiter #(
        .NUM_REQ        (4),
        .TIMEOUT_CYCLES (100),
        .GAP_CYCLES     (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_addr   (req_addr),
        .req_rw     (req_rw),
        .req_wdata  (req_wdata),
        .req_nbytes (req_nbytes),
        .grant      (grant),
        .done       (done),
        .nack       (nack),
        .timeout    (timeout),
        .rdata      (rdata),
        .busy       (busy),
        .eng_start  (eng_start),
        .eng_abort  (eng_abort),
        .eng_addr   (eng_addr),
        .eng_rw     (eng_rw),
        .eng_wdata  (eng_wdata),
        .eng_nbytes (eng_nbytes),
        .eng_done   (eng_done),
        .eng_nack   (eng_nack),
        .eng_rdata  (eng_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (eng_start) start_cnt++;
        if (!$onehot0(grant)) multihot_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns the number of sampled cycles with grant == 0 before a grant appears.
    task automatic wait_grant(output int idle);
        idle = 0;
        tick();
        while (grant == 4'b0000 && idle < 50) begin
            idle++;
            tick();
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (done == 4'b0000 && n < 300);
    endtask

    task automatic engine_reply(input int lat, input logic nk, input logic [15:0] rd);
        repeat (lat) tick();
        eng_done  = 1'b1;
        eng_nack  = nk;
        eng_rdata = rd;
        tick();
        eng_done  = 1'b0;
        eng_nack  = 1'b0;
        eng_rdata = 16'h0000;
    endtask

    initial begin
        int idle;
        int n;
        int k;
        logic early;

        rst        = 1'b1;
        req        = 4'b0000;
        req_rw     = 4'b0000;
        req_addr   = {7'h4B, 7'h4A, 7'h49, 7'h48};
        req_wdata  = {16'h3333, 16'h2222, 16'h1111, 16'h1234};
        req_nbytes = {2'd3, 2'd0, 2'd1, 2'd2};
        eng_done   = 1'b0;
        eng_nack   = 1'b0;
        eng_rdata  = 16'h0000;

        repeat (3) tick();
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_start", 32'(eng_start), 32'h0);
        chk("rst_rdata", 32'(rdata), 32'h0);
        chk("rst_addr", 32'(eng_addr), 32'h0);
        rst = 1'b0;

        // Single write from requester 0.
        req = 4'b0001;
        wait_grant(idle);
        chk("t1_latency", 32'(idle), 32'd0);
        chk("t1_grant", 32'(grant), 32'h1);
        chk("t1_start_early", 32'(eng_start), 32'h0);
        tick();
        chk("t1_start", 32'(eng_start), 32'h1);
        chk("t1_addr", 32'(eng_addr), 32'h48);
        chk("t1_wdata", 32'(eng_wdata), 32'h1234);
        chk("t1_nbytes", 32'(eng_nbytes), 32'd2);
        chk("t1_rw", 32'(eng_rw), 32'h0);
        chk("t1_busy", 32'(busy), 32'h1);
        engine_reply(49, 1'b0, 16'h0000);
        chk("t1_done", 32'(done), 32'h1);
        chk("t1_nack", 32'(nack), 32'h0);
        chk("t1_grant_with_done", 32'(grant), 32'h1);
        req = 4'b0000;
        tick();
        chk("t1_grant_drop", 32'(grant), 32'h0);
        chk("t1_done_pulse", 32'(done), 32'h0);
        repeat (4) tick();
        chk("t1_idle_busy", 32'(busy), 32'h0);
        chk("t1_start_count", 32'(start_cnt), 32'd1);

        // Round robin with all requesters active from a fresh pointer.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b1111;
        for (k = 0; k < 5; k++) begin
            wait_grant(idle);
            chk("rr_gap_idle", 32'(idle), (k == 0) ? 32'd0 : 32'd4);
            chk("rr_grant", 32'(grant), 32'(4'b0001 << (k % 4)));
            tick();
            chk("rr_addr", 32'(eng_addr), 32'(7'h48 + 7'(k % 4)));
            chk("rr_nbytes", 32'(eng_nbytes), ((k % 4) == 1) ? 32'd1 : 32'd2);
            engine_reply(2, 1'b0, 16'h0000);
            chk("rr_done", 32'(done), 32'(4'b0001 << (k % 4)));
            if (k == 4) req = 4'b0000;
        end
        repeat (5) tick();

        // Read result, then rdata holds through a write completion.
        req_rw = 4'b0010;
        req = 4'b0010;
        wait_grant(idle);
        chk("rd_grant", 32'(grant), 32'h2);
        tick();
        chk("rd_rw", 32'(eng_rw), 32'h1);
        engine_reply(5, 1'b0, 16'h0A80);
        chk("rd_done", 32'(done), 32'h2);
        chk("rd_rdata", 32'(rdata), 32'h0A80);
        req = 4'b0100;
        wait_grant(idle);
        chk("wr_gap_idle", 32'(idle), 32'd4);
        chk("wr_grant", 32'(grant), 32'h4);
        tick();
        chk("wr_rw", 32'(eng_rw), 32'h0);
        engine_reply(5, 1'b0, 16'hBEEF);
        chk("wr_done", 32'(done), 32'h4);
        chk("wr_rdata_hold", 32'(rdata), 32'h0A80);

        // Timeout: engine never answers requester 3.
        req = 4'b1001;
        wait_grant(idle);
        chk("to_grant", 32'(grant), 32'h8);
        tick();
        chk("to_start", 32'(eng_start), 32'h1);
        wait_done(n);
        chk("to_cycles", 32'(n), 32'd100);
        chk("to_done", 32'(done), 32'h8);
        chk("to_abort", 32'(eng_abort), 32'h1);
        chk("to_nack", 32'(nack), 32'h1);
        chk("to_timeout", 32'(timeout), 32'h1);
        req = 4'b0001;
        wait_grant(idle);
        chk("to_next_idle", 32'(idle), 32'd4);
        chk("to_next_grant", 32'(grant), 32'h1);
        tick();
        engine_reply(3, 1'b1, 16'h0000);
        chk("nk_done", 32'(done), 32'h1);
        chk("nk_nack", 32'(nack), 32'h1);
        chk("nk_timeout", 32'(timeout), 32'h0);

        // eng_done on the very cycle the timeout would fire.
        req = 4'b0010;
        wait_grant(idle);
        chk("co_grant", 32'(grant), 32'h2);
        tick();
        early = 1'b0;
        repeat (99) begin
            tick();
            if (done != 4'b0000) early = 1'b1;
        end
        eng_done  = 1'b1;
        eng_nack  = 1'b0;
        eng_rdata = 16'h5A5A;
        tick();
        eng_done  = 1'b0;
        eng_rdata = 16'h0000;
        chk("co_no_early_done", 32'(early), 32'h0);
        chk("co_done", 32'(done), 32'h2);
        chk("co_timeout", 32'(timeout), 32'h0);
        chk("co_abort", 32'(eng_abort), 32'h0);
        chk("co_nack", 32'(nack), 32'h0);
        chk("co_rdata", 32'(rdata), 32'h5A5A);

        // Asynchronous reset in the middle of a transaction.
        req = 4'b1000;
        wait_grant(idle);
        chk("ar_grant", 32'(grant), 32'h8);
        tick();
        repeat (3) tick();
        chk("ar_busy_before", 32'(busy), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_grant0", 32'(grant), 32'h0);
        chk("ar_busy0", 32'(busy), 32'h0);
        chk("ar_rdata0", 32'(rdata), 32'h0);
        chk("ar_addr0", 32'(eng_addr), 32'h0);
        chk("ar_nack0", 32'(nack), 32'h0);
        chk("ar_abort0", 32'(eng_abort), 32'h0);
        tick();
        rst = 1'b0;
        req = 4'b0100;
        wait_grant(idle);
        chk("ar_latency", 32'(idle), 32'd0);
        chk("ar_grant2", 32'(grant), 32'h4);
        tick();
        chk("ar_addr2", 32'(eng_addr), 32'h4A);
        engine_reply(2, 1'b0, 16'h0000);
        chk("ar_done2", 32'(done), 32'h4);
        req = 4'b0000;
        tick();

        chk("onehot_grant", 32'(multihot_seen), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2c_txn_arbiter.md
# i2c_txn_arbiter

Round-robin arbiter and sequencer that shares one I2C transaction engine (the bit-level SDA/SCL master inside an `i2cbus` instance) between up to NUM_REQ device pollers (LM75 temperature reader, expander, EEPROM, and similar). It grants the engine to one requester at a time and launches that requester's transaction. It enforces a per-transaction timeout and an inter-transaction bus-idle gap. Each result is returned to its owner with a one-cycle completion pulse.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- TIMEOUT_CYCLES, 2700000, max cycles from eng_start to eng_done (100 ms at 27 MHz)
- GAP_CYCLES, 270, bus-idle cycles enforced after each transaction (0 = none)

- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  request per requester; held high until its done pulse
- req_addr  in  7*NUM_REQ  7-bit device address, slice i = [7i+6:7i]
- req_rw  in  NUM_REQ  1 = read, 0 = write
- req_wdata  in  16*NUM_REQ  write data, slice i = [16i+15:16i]
- req_nbytes  in  2*NUM_REQ  byte count 1 or 2; 0 and 3 are treated as 2
- grant  out  NUM_REQ  one-hot owner of the engine
- done  out  NUM_REQ  one-cycle completion pulse to owner
- nack  out  1  valid with done: 1 = device NACK or timeout
- timeout  out  1  valid with done: 1 = transaction timed out
- rdata  out  16  read data, valid with done, held until next done
- busy  out  1  high in any state other than IDLE
- eng_start  out  1  one-cycle launch pulse to engine
- eng_abort  out  1  one-cycle pulse forcing engine to STOP/idle
- eng_addr, eng_rw, eng_wdata, eng_nbytes  out  7/1/16/2  transaction fields, stable from eng_start until done
- eng_done  in  1  one-cycle engine completion pulse
- eng_nack  in  1  valid with eng_done
- eng_rdata  in  16  valid with eng_done

## Operation
- States: IDLE, START, WAIT, GAP.
- IDLE behaviour:
  - If req != 0, pick a winner by round-robin: scan from index ptr upward with wrap, first set bit wins.
  - Register grant (one-hot) and eng_* fields from the winner's slices, then go to START.
  - If req == 0, stay in IDLE.
- START behaviour:
  - eng_start = 1 for exactly this cycle.
  - Clear the timeout counter, then go to WAIT.
- WAIT behaviour:
  - On eng_done: pulse done[winner] and load nack = eng_nack, timeout = 0, rdata = eng_rdata. rdata is loaded for reads only; writes leave rdata unchanged.
  - Otherwise, when the counter reaches TIMEOUT_CYCLES-1: pulse done[winner] with nack = 1, timeout = 1, and pulse eng_abort.
  - Either exit: drop grant, set ptr = winner+1 (wrapping at NUM_REQ), then go to GAP, or to IDLE if GAP_CYCLES = 0.
- GAP behaviour: count GAP_CYCLES cycles, then go to IDLE. req is ignored during GAP.
- A requester dropping req while granted does not cancel the transaction. The transaction runs to completion and done is still pulsed.
- eng_done and the timeout firing in the same cycle: eng_done wins. No abort is issued and timeout = 0.
- eng_done outside WAIT is ignored.
- Counter width: clog2(TIMEOUT_CYCLES+1) bits, unsigned, saturating. No wrap.
- rst, asynchronous and allowed in any state:
  - State goes to IDLE and ptr to 0.
  - All outputs go to 0, including rdata, grant, and the eng_* fields.
  - No eng_abort is issued, because the engine shares the reset.

## Timing
- Uncontended request latency:
  - req rises before edge N in IDLE.
  - grant is high after edge N.
  - eng_start is high after edge N+1, for one cycle.
- done latency: done pulses in the cycle after the edge that samples eng_done. Equivalently, done is visible 1 cycle after the eng_done pulse.
- Grant window: grant stays high from edge N through the edge that issues done. grant and done are high together in that cycle; grant falls on the next edge.
- Minimum spacing between consecutive eng_start pulses: 3 + GAP_CYCLES + engine latency.
- Timeout: eng_abort and done are issued TIMEOUT_CYCLES cycles after eng_start.

## Test plan
- Single requester 0, write, addr 0x48, wdata 0x1234, nbytes 2; engine returns eng_done after 50 cycles with eng_nack = 0:
  - One eng_start, with eng_addr = 0x48 and eng_wdata = 0x1234.
  - done[0] 1 cycle after eng_done; nack = 0.
- All four req high continuously, GAP_CYCLES = 4: grants go 0,1,2,3,0 in that order.
  - Exactly 4 idle cycles between each done and the next grant.
  - grant is never multi-hot.
- Read, engine returns eng_rdata = 0x0A80: rdata = 0x0A80 with done, and rdata holds after a subsequent write completion.
- Engine never answers, TIMEOUT_CYCLES = 100:
  - eng_abort and done pulse 100 cycles after eng_start, with nack = 1 and timeout = 1.
  - The next requester is granted afterwards.
- eng_done coincident with the final timeout cycle: timeout = 0, no eng_abort, nack follows eng_nack.
- rst asserted mid-WAIT: all outputs read 0 immediately (asynchronous). After release with req = 0b0100, requester 2 is granted (ptr = 0, scan finds bit 2).
